// File: rtl/gf2_div_pkg.sv
// Shared definitions for the serial GF(2)[x] polynomial divider.
package gf2_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_DW = 2048;
    localparam int DEF_VW = 1024;

    // Width of the shift count and the division cycle counter.
    function automatic int CW(input int dw, input int vw);
        return $clog2(dw + vw);
    endfunction

endpackage

// File: rtl/gf2_poly_divider.sv
// Carry-less polynomial divider: serial normalization of the divisor, then
// one quotient bit per cycle of long division over GF(2).
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// NORM  | shifting divisor left until its MSB is set, counting shifts in s
// DIV   | one long-division step per cycle over the bits of a*x^s
// DONE  | publishing q, r (denormalized) with a one-cycle done pulse
module gf2_poly_divider
    import gf2_div_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int VW = DEF_VW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] a,
    input  logic [VW-1:0] b,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] q,
    output logic [VW-1:0] r
);

    localparam int CNTW = CW(DW, VW);

    state_t         state_q, state_d;
    logic [DW-1:0]  a_sh_q, a_sh_d;
    logic [VW-1:0]  d_q, d_d;
    logic [VW-1:0]  rem_q, rem_d;
    logic [DW-1:0]  quo_q, quo_d;
    logic [CNTW-1:0] s_q, s_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic           err_q, err_d;
    logic           done_q, done_d;
    logic           busy_q, busy_d;
    logic [DW-1:0]  q_q, q_d;
    logic [VW-1:0]  r_q, r_d;

    logic [VW-1:0]  step;
    logic           qbit;

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        d_d     = d_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        q_d     = q_q;
        r_d     = r_q;
        done_d  = 1'b0;
        busy_d  = (state_q != IDLE);
        step    = '0;
        qbit    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d = a;
                    d_d    = b;
                    rem_d  = '0;
                    quo_d  = '0;
                    s_d    = '0;
                    cnt_d  = '0;
                    q_d    = '0;
                    r_d    = '0;
                    if (b == '0) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = NORM;
                    end
                end
            end
            NORM: begin
                if (!d_q[VW-1]) begin
                    d_d = d_q << 1;
                    s_d = s_q + CNTW'(1);
                end else begin
                    cnt_d   = CNTW'(DW - 1) + s_q;
                    state_d = DIV;
                end
            end
            DIV: begin
                // A fills with zeros, so the trailing s bits of a*x^s come for free.
                step = {rem_q[VW-2:0], a_sh_q[DW-1]};
                qbit = step[VW-1];
                if (qbit) begin
                    step = step ^ d_q;
                end
                rem_d  = step;
                quo_d  = {quo_q[DW-2:0], qbit};
                a_sh_d = a_sh_q << 1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            DONE: begin
                q_d     = quo_q;
                r_d     = rem_q >> s_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            d_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            d_q     <= d_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            q_q     <= q_d;
            r_q     <= r_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;
    assign q    = q_q;
    assign r    = r_q;

endmodule

// File: tb/tb_gf2_poly_divider.sv
// Self-checking bench for gf2_poly_divider: a small 8/4 instance and a
// default-width instance, checked against a long-division reference model.
module tb_gf2_poly_divider;

    localparam int SDW = 8;
    localparam int SVW = 4;
    localparam int LDW = 2048;
    localparam int LVW = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic           s_start, s_busy, s_done, s_err;
    logic [SDW-1:0] s_a, s_q;
    logic [SVW-1:0] s_b, s_r;

    logic           l_start, l_busy, l_done, l_err;
    logic [LDW-1:0] l_a, l_q;
    logic [LVW-1:0] l_b, l_r;

    gf2_poly_divider #(.DW(SDW), .VW(SVW)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .a(s_a), .b(s_b),
        .busy(s_busy), .done(s_done), .err(s_err), .q(s_q), .r(s_r)
    );

    gf2_poly_divider u_large (
        .clk(clk), .rst(rst), .start(l_start), .a(l_a), .b(l_b),
        .busy(l_busy), .done(l_done), .err(l_err), .q(l_q), .r(l_r)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [2047:0] act, input logic [2047:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (low 128 bits)", name, act[127:0], exp[127:0]);
        end
    endtask

    function automatic int deg_of(input logic [2047:0] v);
        for (int i = 2047; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    // Schoolbook long division on the widest operands.
    function automatic void ref_div(input logic [2047:0] av, input logic [2047:0] bv,
                                    output logic [2047:0] qv, output logic [2047:0] rv);
        int db;
        db = deg_of(bv);
        qv = '0;
        rv = av;
        if (db < 0) begin
            rv = '0;
            return;
        end
        for (int i = 2047; i >= db; i--) begin
            if (rv[i]) begin
                rv = rv ^ (bv << (i - db));
                qv[i - db] = 1'b1;
            end
        end
    endfunction

    function automatic int ref_lat(input int dw, input int vw, input logic [2047:0] bv);
        int db;
        db = deg_of(bv);
        if (db < 0) return 1;
        return dw + 2 * (vw - 1 - db) + 2;
    endfunction

    function automatic logic [2047:0] clmul(input logic [1023:0] x, input logic [1023:0] y);
        logic [2047:0] c;
        c = '0;
        for (int i = 0; i < 1024; i++) if (y[i]) c = c ^ ({1024'b0, x} << i);
        return c;
    endfunction

    task automatic run_op(input bit big, input logic [2047:0] av, input logic [1023:0] bv,
                          input logic [2047:0] eq, input logic [2047:0] er, input logic ee,
                          input int ecyc, input string name);
        int cyc;
        int busy_n;
        logic dn;
        @(negedge clk);
        if (big) begin
            l_a = av; l_b = bv; l_start = 1'b1;
        end else begin
            s_a = av[SDW-1:0]; s_b = bv[SVW-1:0]; s_start = 1'b1;
        end
        @(posedge clk); #1;
        s_start = 1'b0;
        l_start = 1'b0;
        cyc = 0; busy_n = 0; dn = 1'b0;
        while (!dn && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
            if (big ? l_busy : s_busy) busy_n++;
            dn = big ? l_done : s_done;
        end
        check({name, "/done_cycle"}, cyc, ecyc);
        check({name, "/busy_cycles"}, busy_n, ecyc);
        check({name, "/q"}, big ? l_q : {2040'b0, s_q}, eq);
        check({name, "/r"}, big ? {1024'b0, l_r} : {2044'b0, s_r}, er);
        check({name, "/err"}, big ? l_err : s_err, ee);
        @(posedge clk); #1;
        check({name, "/done_fall"}, big ? l_done : s_done, 1'b0);
        check({name, "/busy_fall"}, big ? l_busy : s_busy, 1'b0);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] q;
        logic [3:0] r;
        logic       e;
        int         cyc;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [2047:0] eq, er, av;
        logic [1023:0] p, m, bv;
        int cyc;
        int extra;
        int dones[$];

        vecs[0] = '{8'h57, 4'h3, 8'h32, 4'h1, 1'b0, 14};
        vecs[1] = '{8'h05, 4'h9, 8'h00, 4'h5, 1'b0, 10};
        vecs[2] = '{8'hA7, 4'h1, 8'hA7, 4'h0, 1'b0, 16};
        vecs[3] = '{8'h6C, 4'h0, 8'h00, 4'h0, 1'b1, 1};
        vecs[4] = '{8'hFF, 4'hF, 8'h11, 4'h0, 1'b0, 10};
        vecs[5] = '{8'h80, 4'h2, 8'h40, 4'h0, 1'b0, 14};

        rst = 1'b1;
        s_start = 1'b0; s_a = '0; s_b = '0;
        l_start = 1'b0; l_a = '0; l_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset/busy", s_busy, 1'b0);
        check("reset/done", s_done, 1'b0);
        check("reset/err", s_err, 1'b0);
        check("reset/q", s_q, 8'h00);
        check("reset/r", s_r, 4'h0);
        check("reset/large_q", l_q, '0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            run_op(1'b0, {2040'b0, vecs[i].a}, {1020'b0, vecs[i].b}, {2040'b0, vecs[i].q},
                   {2044'b0, vecs[i].r}, vecs[i].e, vecs[i].cyc, $sformatf("vec%0d", i));

        for (int i = 0; i < 30; i++) begin
            av = {2040'b0, 8'($urandom)};
            bv = {1020'b0, 4'($urandom_range(0, 15))};
            ref_div(av, {1024'b0, bv}, eq, er);
            run_op(1'b0, av, bv, eq, er, bv == '0, ref_lat(SDW, SVW, {1024'b0, bv}),
                   $sformatf("rand%0d", i));
        end

        // start pulsed mid-operation must be ignored
        @(negedge clk);
        s_a = 8'h57; s_b = 4'h3; s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        cyc = 0;
        repeat (5) begin @(posedge clk); #1; cyc++; end
        s_a = 8'hFF; s_b = 4'h1; s_start = 1'b1;
        @(posedge clk); #1; cyc++;
        s_start = 1'b0;
        while (!s_done && cyc < 100) begin @(posedge clk); #1; cyc++; end
        check("ignore/done_cycle", cyc, 14);
        check("ignore/q", s_q, 8'h32);
        check("ignore/r", s_r, 4'h1);
        extra = 0;
        repeat (20) begin @(posedge clk); #1; if (s_done || s_busy) extra++; end
        check("ignore/no_second_op", extra, 0);

        // start held through the DONE cycle is accepted on the following IDLE cycle
        @(negedge clk);
        s_a = 8'h05; s_b = 4'h9; s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        cyc = 0;
        while (cyc < 40) begin
            @(posedge clk); #1; cyc++;
            if (s_done) begin
                dones.push_back(cyc);
                if (dones.size() == 1) begin
                    check("b2b/first_q", s_q, 8'h00);
                    check("b2b/first_r", s_r, 4'h5);
                end else begin
                    check("b2b/second_q", s_q, 8'h32);
                    check("b2b/second_r", s_r, 4'h1);
                end
            end
            if (cyc == 9) begin s_a = 8'h57; s_b = 4'h3; s_start = 1'b1; end
            if (cyc == 11) s_start = 1'b0;
        end
        check("b2b/done_count", dones.size(), 2);
        check("b2b/first_cycle", dones.size() > 0 ? dones[0] : -1, 10);
        check("b2b/second_cycle", dones.size() > 1 ? dones[1] : -1, 25);

        // default widths: product of a multiplier divided by one operand
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 32; i++) begin
                p[i*32 +: 32] = $urandom;
                m[i*32 +: 32] = $urandom;
            end
            p[1023] = 1'b0;
            m[1023] = 1'b1;
            run_op(1'b1, clmul(p, m), m, {1024'b0, p}, '0, 1'b0, 2050,
                   $sformatf("clmul%0d", k));
        end

        for (int i = 0; i < 64; i++) av[i*32 +: 32] = $urandom;
        bv = '0;
        for (int i = 0; i < 4; i++) bv[i*32 +: 32] = $urandom;
        bv[1023:100] = '0;
        bv[99] = 1'b1;
        ref_div(av, {1024'b0, bv}, eq, er);
        run_op(1'b1, av, bv, eq, er, 1'b0, ref_lat(LDW, LVW, {1024'b0, bv}), "large_rand");

        // reset during DIV aborts with no done pulse
        @(negedge clk);
        s_a = 8'hA7; s_b = 4'h1; s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("abort/busy_before", s_busy, 1'b1);
        rst = 1'b1;
        #1;
        check("abort/busy", s_busy, 1'b0);
        check("abort/done", s_done, 1'b0);
        check("abort/q", s_q, 8'h00);
        check("abort/r", s_r, 4'h0);
        check("abort/err", s_err, 1'b0);
        check("abort/large_q", l_q, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        repeat (20) begin @(posedge clk); #1; if (s_done) extra++; end
        check("abort/no_done", extra, 0);
        run_op(1'b0, {2040'b0, 8'hA7}, {1020'b0, 4'h1}, {2040'b0, 8'hA7}, '0, 1'b0, 16, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
